// File: rtl/sqrt_host_ctrl_if.sv
// Host-side operand and result streams of sqrt_host_ctrl.
interface sqrt_host_ctrl_if;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] IN_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] OUT_DATA;
    logic [3:0]  OUT_FLAGS;

    // Producer/consumer side (host).
    modport master (
        output IN_VALID, IN_DATA, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_FLAGS
    );

    // Controller side.
    modport slave (
        input  IN_VALID, IN_DATA, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_FLAGS
    );
endinterface

// File: rtl/sqrt_host_ctrl.sv
// Host sequencer for the fp16 square-root core: accepts one operand at a time,
// runs the core's enable/bus protocol, and queues result+flags in a small FIFO.
// A watchdog replaces a result that never arrives with a quiet-NaN timeout entry.
module sqrt_host_ctrl #(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    sqrt_host_ctrl_if.slave  host,
    inout  wire  [15:0]      SQ_DATA,
    output logic             SQ_ENABLE,
    input  logic             SQ_IS_NAN,
    input  logic             SQ_IS_PINF,
    input  logic             SQ_IS_NINF,
    input  logic             SQ_RESULT,
    output logic             BUSY
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [7:0]  WAIT_LAST     = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_ENTRY = {4'b1000, 16'h7E00};

    logic [1:0]  state;
    logic [15:0] op_reg;
    logic [7:0]  wait_cnt;
    logic [19:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic        full;
    logic        empty;
    logic        accept;
    logic        capture;
    logic        timeout;
    logic        push;
    logic        pop;
    logic        drive_bus;
    logic [19:0] push_entry;
    logic [19:0] head_entry;

    // Pointer MSBs differ only when the write side has lapped the read side.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Only IDLE accepts, and only with a free slot, so a push never meets a full FIFO.
    assign host.IN_READY = RESET_N && (state == S_IDLE) && !full;
    assign accept        = host.IN_VALID && host.IN_READY;

    // WAIT cycle 0 is skipped: the core is not driving yet and SQ_RESULT may be stale.
    assign capture = (state == S_WAIT) && (wait_cnt != 8'd0) && SQ_RESULT;
    assign timeout = (state == S_WAIT) && !capture && (wait_cnt == WAIT_LAST);
    assign push    = capture || timeout;
    assign pop     = host.OUT_VALID && host.OUT_READY;

    assign push_entry = capture ? {1'b0, SQ_IS_NINF, SQ_IS_PINF, SQ_IS_NAN, SQ_DATA}
                                : TIMEOUT_ENTRY;

    // Show-ahead head of the result FIFO.
    assign head_entry     = fifo_mem[rd_ptr[AW-1:0]];
    assign host.OUT_VALID = RESET_N && !empty;
    assign host.OUT_DATA  = head_entry[15:0];
    assign host.OUT_FLAGS = head_entry[19:16];

    // Bus is driven in LOAD only; WAIT cycle 0 is the turnaround gap before the core drives.
    assign drive_bus = RESET_N && (state == S_LOAD);
    assign SQ_DATA   = drive_bus ? op_reg : 16'bz;
    assign SQ_ENABLE = RESET_N && ((state == S_LOAD) || (state == S_WAIT));
    assign BUSY      = RESET_N && (state != S_IDLE);

    // Sequencer FSM, watchdog counter and FIFO pointers; reset discards in-flight work.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            op_reg   <= 16'h0000;
            wait_cnt <= 8'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_reg <= host.IN_DATA;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    wait_cnt <= 8'd0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (push) begin
                        state <= S_RELEASE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Result storage; pointers alone define validity, so the array needs no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    push_never_full: assert property (@(posedge CLK) disable iff (!RESET_N) !(push && full));
endmodule
